// File: rtl/sdram_cmd_decoder.sv
// SDRAM command-bus decoder: decodes the sampled control pins into command codes,
// tracks bank/row state and power state, and flags protocol/timing violations.
module sdram_cmd_decoder #(
  parameter int unsigned TRCD = 2,
  parameter int unsigned TRP  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cke,
  input  logic        cs_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        we_n,
  input  logic [1:0]  ba,
  input  logic [11:0] addr,
  output logic [3:0]  cmd_out,
  output logic        cmd_valid,
  output logic [21:0] addr_out,
  output logic [11:0] mode_reg,
  output logic [3:0]  bank_active,
  output logic [1:0]  pwr_state,
  output logic [3:0]  err,
  output logic [3:0]  err_sticky
);

  typedef enum logic [3:0] {
    CMD_DESL  = 4'h0, CMD_NOP   = 4'h1, CMD_MRS   = 4'h2, CMD_ACT  = 4'h3,
    CMD_READ  = 4'h4, CMD_READA = 4'h5, CMD_WRIT  = 4'h6, CMD_WRITA = 4'h7,
    CMD_PRE   = 4'h8, CMD_PALL  = 4'h9, CMD_BST   = 4'hA, CMD_REF  = 4'hB,
    CMD_SELF  = 4'hC, CMD_SUP   = 4'hD, CMD_REC   = 4'hE
  } cmd_e;

  typedef enum logic [1:0] {
    PWR_NORMAL = 2'b00,
    PWR_SELF   = 2'b01,
    PWR_PDOWN  = 2'b10
  } pwr_e;

  logic        cke_prev_q;
  cmd_e        cmd_q, cmd_d;
  logic        valid_q, valid_d;
  logic [21:0] addr_q, addr_d;
  logic [11:0] mode_q, mode_d;
  logic [3:0]  active_q, active_d;
  pwr_e        pwr_q, pwr_d;
  logic [3:0]  err_q, err_d;
  logic [3:0]  sticky_q, sticky_d;
  logic [11:0] row_q [4];
  logic [11:0] row_d [4];
  logic [2:0]  cnt_q [4];
  logic [2:0]  cnt_d [4];
  logic [3:0]  cnt_clr;
  logic [2:0]  rcw;

  assign rcw = {ras_n, cas_n, we_n};

  always_comb begin
    cmd_d    = CMD_NOP;
    addr_d   = '0;
    err_d    = '0;
    mode_d   = mode_q;
    active_d = active_q;
    pwr_d    = pwr_q;
    row_d    = row_q;
    cnt_clr  = '0;

    if (!cke_prev_q && cke) begin
      cmd_d = CMD_REC;
      if (pwr_q == PWR_NORMAL) err_d[2] = 1'b1;
      pwr_d = PWR_NORMAL;
    end else if (cke_prev_q && !cke) begin
      if (!cs_n) begin
        case (rcw)
          3'b111: begin
            cmd_d = CMD_SELF;
            pwr_d = PWR_SELF;
            if (|active_q) err_d[0] = 1'b1;
          end
          3'b000: begin
            cmd_d = CMD_SUP;
            pwr_d = PWR_PDOWN;
            if (|active_q) err_d[0] = 1'b1;
          end
          default: err_d[3] = 1'b1;
        endcase
      end
    end else if (!cke_prev_q && !cke) begin
      if (!cs_n && rcw != 3'b111) err_d[2] = 1'b1;
    end else if (cs_n) begin
      cmd_d = CMD_DESL;
    end else begin
      case (rcw)
        3'b011: begin
          cmd_d = CMD_ACT;
          addr_d = {ba, addr, 8'h00};
          // Timing is only judged against a precharge when the bank was idle.
          if (active_q[ba]) err_d[0] = 1'b1;
          else if (32'(cnt_q[ba]) < TRP) err_d[1] = 1'b1;
          active_d[ba] = 1'b1;
          row_d[ba]    = addr;
          cnt_clr[ba]  = 1'b1;
        end
        3'b101, 3'b100: begin
          if (rcw == 3'b101) cmd_d = addr[10] ? CMD_READA : CMD_READ;
          else               cmd_d = addr[10] ? CMD_WRITA : CMD_WRIT;
          addr_d = {ba, row_q[ba], addr[7:0]};
          if (!active_q[ba]) err_d[0] = 1'b1;
          else if (32'(cnt_q[ba]) < TRCD) err_d[1] = 1'b1;
          if (addr[10]) begin
            active_d[ba] = 1'b0;
            cnt_clr[ba]  = 1'b1;
          end
        end
        3'b010: begin
          if (addr[10]) begin
            cmd_d    = CMD_PALL;
            active_d = '0;
            cnt_clr  = '1;
          end else begin
            cmd_d        = CMD_PRE;
            addr_d       = {ba, 20'h0};
            active_d[ba] = 1'b0;
            cnt_clr[ba]  = 1'b1;
          end
        end
        3'b110: cmd_d = CMD_BST;
        3'b001: begin
          cmd_d = CMD_REF;
          if (|active_q) err_d[0] = 1'b1;
        end
        3'b000: begin
          cmd_d  = CMD_MRS;
          addr_d = {10'h000, addr};
          mode_d = addr;
          if (|active_q) err_d[0] = 1'b1;
        end
        default: cmd_d = CMD_NOP;
      endcase
    end

    valid_d  = (cmd_d != CMD_DESL) && (cmd_d != CMD_NOP);
    sticky_d = sticky_q | err_d;

    for (int unsigned b = 0; b < 4; b++) begin
      if (cnt_clr[b])            cnt_d[b] = '0;
      else if (cnt_q[b] == 3'h7) cnt_d[b] = 3'h7;
      else                       cnt_d[b] = cnt_q[b] + 3'h1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cke_prev_q <= 1'b1;
      cmd_q      <= CMD_NOP;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      mode_q     <= '0;
      active_q   <= '0;
      pwr_q      <= PWR_NORMAL;
      err_q      <= '0;
      sticky_q   <= '0;
      for (int unsigned b = 0; b < 4; b++) begin
        row_q[b] <= '0;
        cnt_q[b] <= 3'h7;
      end
    end else begin
      cke_prev_q <= cke;
      cmd_q      <= cmd_d;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      mode_q     <= mode_d;
      active_q   <= active_d;
      pwr_q      <= pwr_d;
      err_q      <= err_d;
      sticky_q   <= sticky_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
    end
  end

  assign cmd_out     = cmd_q;
  assign cmd_valid   = valid_q;
  assign addr_out    = addr_q;
  assign mode_reg    = mode_q;
  assign bank_active = active_q;
  assign pwr_state   = pwr_q;
  assign err         = err_q;
  assign err_sticky  = sticky_q;

endmodule

// File: tb/tb_sdram_cmd_decoder.sv
// Directed-vector bench for sdram_cmd_decoder with hand-computed expectations.
module tb_sdram_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst, cke, cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba;
  logic [11:0] addr;
  logic [3:0]  cmd_out;
  logic        cmd_valid;
  logic [21:0] addr_out;
  logic [11:0] mode_reg;
  logic [3:0]  bank_active;
  logic [1:0]  pwr_state;
  logic [3:0]  err;
  logic [3:0]  err_sticky;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sdram_cmd_decoder #(.TRCD(2), .TRP(2)) dut (
    .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n),
    .we_n(we_n), .ba(ba), .addr(addr), .cmd_out(cmd_out), .cmd_valid(cmd_valid),
    .addr_out(addr_out), .mode_reg(mode_reg), .bank_active(bank_active),
    .pwr_state(pwr_state), .err(err), .err_sticky(err_sticky)
  );

  // Apply pins, clock them in, and return 1 time unit after the edge.
  task automatic pins(input logic k, input logic cs, input logic [2:0] rcw,
                      input logic [1:0] b, input logic [11:0] a);
    cke = k; cs_n = cs; {ras_n, cas_n, we_n} = rcw; ba = b; addr = a;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    pins(1'b1, 1'b0, 3'b111, 2'd0, 12'h000);
    pins(1'b1, 1'b0, 3'b111, 2'd0, 12'h000);
    n_checks++; if (cmd_out !== 4'h1) $display("FAIL reset_cmd got %h want 1", cmd_out); else n_pass++;
    n_checks++; if (cmd_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", cmd_valid); else n_pass++;
    n_checks++; if (addr_out !== 22'h0) $display("FAIL reset_addr got %h want 0", addr_out); else n_pass++;
    n_checks++; if (mode_reg !== 12'h0) $display("FAIL reset_mode got %h want 0", mode_reg); else n_pass++;
    n_checks++; if (bank_active !== 4'h0) $display("FAIL reset_active got %b want 0", bank_active); else n_pass++;
    n_checks++; if (pwr_state !== 2'b00) $display("FAIL reset_pwr got %b want 00", pwr_state); else n_pass++;
    n_checks++; if (err !== 4'h0) $display("FAIL reset_err got %b want 0", err); else n_pass++;
    n_checks++; if (err_sticky !== 4'h0) $display("FAIL reset_sticky got %b want 0", err_sticky); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_mrs;
    pins(1'b1, 1'b0, 3'b000, 2'd0, 12'h022);
    n_checks++; if (cmd_out !== 4'h2) $display("FAIL mrs_cmd got %h want 2", cmd_out); else n_pass++;
    n_checks++; if (cmd_valid !== 1'b1) $display("FAIL mrs_valid got %b want 1", cmd_valid); else n_pass++;
    n_checks++; if (mode_reg !== 12'h022) $display("FAIL mrs_mode got %h want 022", mode_reg); else n_pass++;
    n_checks++; if (addr_out !== 22'h000022) $display("FAIL mrs_addr got %h want 000022", addr_out); else n_pass++;
    n_checks++; if (err !== 4'h0) $display("FAIL mrs_err got %b want 0", err); else n_pass++;
    pins(1'b1, 1'b0, 3'b111, 2'd0, 12'h000);
    n_checks++; if (cmd_out !== 4'h1 || cmd_valid !== 1'b0)
      $display("FAIL nop_decode got %h/%b want 1/0", cmd_out, cmd_valid); else n_pass++;
    n_checks++; if (mode_reg !== 12'h022) $display("FAIL mode_hold got %h want 022", mode_reg); else n_pass++;
    pins(1'b1, 1'b1, 3'b011, 2'd0, 12'h000);
    n_checks++; if (cmd_out !== 4'h0 || cmd_valid !== 1'b0)
      $display("FAIL desl_decode got %h/%b want 0/0", cmd_out, cmd_valid); else n_pass++;
  endtask

  task automatic test_act_read;
    pins(1'b1, 1'b0, 3'b011, 2'd1, 12'h0AB);
    n_checks++; if (cmd_out !== 4'h3) $display("FAIL act_cmd got %h want 3", cmd_out); else n_pass++;
    n_checks++; if (addr_out !== 22'h10AB00) $display("FAIL act_addr got %h want 10ab00", addr_out); else n_pass++;
    n_checks++; if (bank_active !== 4'b0010) $display("FAIL act_active got %b want 0010", bank_active); else n_pass++;
    pins(1'b1, 1'b0, 3'b001, 2'd0, 12'h000);
    n_checks++; if (cmd_out !== 4'hB || err !== 4'b0001)
      $display("FAIL ref_active got %h/%b want b/0001", cmd_out, err); else n_pass++;
    pins(1'b1, 1'b0, 3'b111, 2'd0, 12'h000);
    pins(1'b1, 1'b0, 3'b101, 2'd1, 12'h010);
    n_checks++; if (cmd_out !== 4'h4) $display("FAIL read_cmd got %h want 4", cmd_out); else n_pass++;
    n_checks++; if (addr_out !== 22'h10AB10) $display("FAIL read_addr got %h want 10ab10", addr_out); else n_pass++;
    n_checks++; if (err !== 4'h0) $display("FAIL read_err got %b want 0", err); else n_pass++;
    pins(1'b1, 1'b0, 3'b010, 2'd1, 12'h000);
    n_checks++; if (cmd_out !== 4'h8 || addr_out !== 22'h100000 || bank_active !== 4'h0)
      $display("FAIL pre got %h/%h/%b want 8/100000/0000", cmd_out, addr_out, bank_active); else n_pass++;
  endtask

  task automatic test_timing;
    pins(1'b1, 1'b0, 3'b011, 2'd2, 12'h055);
    pins(1'b1, 1'b0, 3'b101, 2'd2, 12'h400);
    n_checks++; if (cmd_out !== 4'h5) $display("FAIL reada_cmd got %h want 5", cmd_out); else n_pass++;
    n_checks++; if (err !== 4'b0010) $display("FAIL trcd_err got %b want 0010", err); else n_pass++;
    n_checks++; if (bank_active !== 4'h0) $display("FAIL reada_active got %b want 0000", bank_active); else n_pass++;
    n_checks++; if (err_sticky[1] !== 1'b1) $display("FAIL trcd_sticky got %b want x1x", err_sticky); else n_pass++;
    pins(1'b1, 1'b0, 3'b011, 2'd2, 12'h077);
    n_checks++; if (cmd_out !== 4'h3 || err !== 4'b0010)
      $display("FAIL trp_err got %h/%b want 3/0010", cmd_out, err); else n_pass++;
    pins(1'b1, 1'b0, 3'b010, 2'd2, 12'h000);
    n_checks++; if (addr_out !== 22'h200000 || bank_active !== 4'h0)
      $display("FAIL pre2 got %h/%b want 200000/0000", addr_out, bank_active); else n_pass++;
  endtask

  task automatic test_idle_write;
    pins(1'b1, 1'b0, 3'b100, 2'd3, 12'h000);
    n_checks++; if (cmd_out !== 4'h6) $display("FAIL writ_cmd got %h want 6", cmd_out); else n_pass++;
    n_checks++; if (err !== 4'b0001) $display("FAIL writ_idle_err got %b want 0001", err); else n_pass++;
    n_checks++; if (addr_out !== 22'h300000) $display("FAIL writ_addr got %h want 300000", addr_out); else n_pass++;
  endtask

  task automatic test_power;
    pins(1'b1, 1'b0, 3'b010, 2'd0, 12'h400);
    n_checks++; if (cmd_out !== 4'h9 || bank_active !== 4'h0 || err !== 4'h0)
      $display("FAIL pall got %h/%b/%b want 9/0000/0000", cmd_out, bank_active, err); else n_pass++;
    pins(1'b0, 1'b0, 3'b111, 2'd0, 12'h000);
    n_checks++; if (cmd_out !== 4'hC || pwr_state !== 2'b01 || err !== 4'h0)
      $display("FAIL self got %h/%b/%b want c/01/0000", cmd_out, pwr_state, err); else n_pass++;
    pins(1'b0, 1'b0, 3'b111, 2'd0, 12'h000);
    n_checks++; if (cmd_out !== 4'h1 || cmd_valid !== 1'b0 || err !== 4'h0)
      $display("FAIL cke_low_nop got %h/%b/%b want 1/0/0000", cmd_out, cmd_valid, err); else n_pass++;
    pins(1'b1, 1'b1, 3'b111, 2'd0, 12'h000);
    n_checks++; if (cmd_out !== 4'hE || pwr_state !== 2'b00 || err !== 4'h0)
      $display("FAIL rec got %h/%b/%b want e/00/0000", cmd_out, pwr_state, err); else n_pass++;
    pins(1'b0, 1'b0, 3'b010, 2'd0, 12'h000);
    n_checks++; if (cmd_out !== 4'h1 || err !== 4'b1000)
      $display("FAIL illegal_entry got %h/%b want 1/1000", cmd_out, err); else n_pass++;
    pins(1'b0, 1'b0, 3'b011, 2'd0, 12'h000);
    n_checks++; if (cmd_out !== 4'h1 || err !== 4'b0100)
      $display("FAIL cke_low_cmd got %h/%b want 1/0100", cmd_out, err); else n_pass++;
    pins(1'b1, 1'b1, 3'b111, 2'd0, 12'h000);
    n_checks++; if (cmd_out !== 4'hE || err !== 4'b0100 || pwr_state !== 2'b00)
      $display("FAIL rec_normal got %h/%b/%b want e/0100/00", cmd_out, err, pwr_state); else n_pass++;
    pins(1'b1, 1'b0, 3'b011, 2'd0, 12'h123);
    n_checks++; if (err !== 4'h0 || bank_active !== 4'b0001)
      $display("FAIL act0 got %b/%b want 0000/0001", err, bank_active); else n_pass++;
    pins(1'b0, 1'b0, 3'b000, 2'd0, 12'h000);
    n_checks++; if (cmd_out !== 4'hD || pwr_state !== 2'b10 || err !== 4'b0001)
      $display("FAIL sup_active got %h/%b/%b want d/10/0001", cmd_out, pwr_state, err); else n_pass++;
    pins(1'b1, 1'b1, 3'b111, 2'd0, 12'h000);
    n_checks++; if (cmd_out !== 4'hE || pwr_state !== 2'b00 || err !== 4'h0)
      $display("FAIL rec_pdown got %h/%b/%b want e/00/0000", cmd_out, pwr_state, err); else n_pass++;
  endtask

  task automatic test_reset_mid;
    n_checks++; if (err_sticky !== 4'hF) $display("FAIL sticky_accum got %b want 1111", err_sticky); else n_pass++;
    rst = 1'b1;
    pins(1'b1, 1'b0, 3'b011, 2'd3, 12'h0FF);
    n_checks++; if (bank_active !== 4'h0 || cmd_out !== 4'h1 || cmd_valid !== 1'b0)
      $display("FAIL rst_priority got %b/%h/%b want 0000/1/0", bank_active, cmd_out, cmd_valid); else n_pass++;
    n_checks++; if (err_sticky !== 4'h0 || mode_reg !== 12'h0)
      $display("FAIL rst_clear got %b/%h want 0000/000", err_sticky, mode_reg); else n_pass++;
    rst = 1'b0;
    pins(1'b1, 1'b0, 3'b011, 2'd0, 12'h000);
    n_checks++; if (cmd_out !== 4'h3 || err !== 4'h0 || bank_active !== 4'b0001)
      $display("FAIL act_after_rst got %h/%b/%b want 3/0000/0001", cmd_out, err, bank_active); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; cke = 1'b1; cs_n = 1'b1; {ras_n, cas_n, we_n} = 3'b111; ba = '0; addr = '0;
    test_reset;
    test_mrs;
    test_act_read;
    test_timing;
    test_idle_write;
    test_power;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sdram_cmd_decoder.md
SDRAM_CMD_DECODER -- requirements
Module: sdram_cmd_decoder

Interface
REQ-001 Parameter TRCD, default 2: minimum cycles from ACT to READ/READA/WRIT/WRITA on the same bank.
REQ-002 Parameter TRP, default 2: minimum cycles from PRE/PALL to ACT on an affected bank.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 cke, cs_n, ras_n, cas_n, we_n  in  1 each  SDRAM control pins, sampled every clk.
REQ-006 ba  in  2  bank address pins.
REQ-007 addr  in  12  address pins.
REQ-008 cmd_out  out  4  decoded command code: DESL 0000, NOP 0001, MRS 0010, ACT 0011, READ 0100, READA 0101, WRIT 0110, WRITA 0111, PRE 1000, PALL 1001, BST 1010, REF 1011, SELF 1100, SUP 1101, REC 1110.
REQ-009 cmd_valid  out  1  one-cycle strobe; asserted for every decoded command except DESL and NOP.
REQ-010 addr_out  out  22  reconstructed logical address {bank[21:20], row[19:8], col[7:0]}.
REQ-011 mode_reg  out  12  last MRS value.
REQ-012 bank_active  out  4  per-bank open flag.
REQ-013 pwr_state  out  2  00 NORMAL, 01 SELF_REFRESH, 10 POWER_DOWN.
REQ-014 err  out  4  one-cycle violation pulse: [0] state, [1] timing, [2] power, [3] illegal pin combination.
REQ-015 err_sticky  out  4  OR-accumulation of err, cleared only by rst.

Function
REQ-016 Inputs are registered; every output reflects the pins sampled one edge earlier (latency 1 cycle).
REQ-017 Decoding uses the registered cke and the previous registered cke (cke_prev).
REQ-018 cke_prev=0 and cke=1: REC, regardless of other pins.
REQ-019 cke_prev=1 and cke=0, with cs_n=0: ras/cas/we=111 -> SELF; 000 -> SUP; any other -> NOP with err[3].
REQ-020 cke_prev=0 and cke=0: NOP, no strobe; err[2] if cs_n=0 and ras/cas/we is not 111.
REQ-021 cke=1 and cke_prev=1, cs_n=1: DESL.
REQ-022 cke=1 and cke_prev=1, cs_n=0, ras/cas/we: 111 NOP, 011 ACT, 101 READ (addr[10]=1 -> READA), 100 WRIT (addr[10]=1 -> WRITA), 010 PRE (addr[10]=1 -> PALL), 110 BST, 001 REF, 000 MRS.
REQ-023 addr_out for ACT: {ba, addr, 8'h00}; for READ/WRIT variants: {ba, open_row[ba], addr[7:0]}; for PRE: {ba, 20'h0}; for MRS: {2'b00, 8'h00, addr}; all other commands: 0.
REQ-024 ACT sets bank_active[ba] and stores open_row[ba]=addr; ACT to an already active bank sets err[0] and overwrites the row.
REQ-025 READ/WRIT to an idle bank sets err[0]; READA/WRITA additionally clear bank_active[ba] on the same edge.
REQ-026 PRE clears bank_active[ba]; PALL clears all four; precharging an idle bank is legal.
REQ-027 MRS or REF while any bank_active bit is set sets err[0]; MRS still loads mode_reg.
REQ-028 Per-bank 3-bit saturating cycle counter: reset to 0 on ACT/PRE/PALL/READA/WRITA to that bank, increments otherwise, saturates at 7.
REQ-029 READ/WRIT variant with counter < TRCD after ACT on that bank sets err[1]; ACT with counter < TRP after a precharge sets err[1].
REQ-030 SELF enters SELF_REFRESH; SUP enters POWER_DOWN; REC returns to NORMAL; REC while NORMAL sets err[2].
REQ-031 SELF or SUP while any bank is active sets err[0].
REQ-032 Simultaneous errors set all applicable err bits in the same cycle.

Reset
REQ-033 On rst: cmd_out=0001, cmd_valid=0, addr_out=0, mode_reg=0, bank_active=0, pwr_state=00, err=0, err_sticky=0, all counters=7, cke_prev=1, open rows=0.
REQ-034 rst asserted mid-operation takes priority over any decode on that edge; the first post-reset edge decodes normally.

Verification
REQ-035 MRS with addr=12'h022 -> next cycle cmd_out=0010, cmd_valid=1, mode_reg=12'h022, addr_out=22'h000022.
REQ-036 ACT ba=1 addr=12'h0AB, two NOPs, READ ba=1 addr=12'h010 -> cmd_out=0100, addr_out={2'b01,12'h0AB,8'h10}, err=0.
REQ-037 ACT ba=2, READA ba=2 on the next cycle -> err[1]=1 with READA; bank_active[2]=0 afterwards; err_sticky[1]=1.
REQ-038 WRIT ba=3 with all banks idle -> cmd_out=0110, err[0]=1.
REQ-039 PALL, then cke 1->0 with pins 111 -> SELF, pwr_state=01; cke 0->1 -> REC, pwr_state=00, err=0.
REQ-040 ACT ba=0 followed by rst pulse -> bank_active=0, counters=7; immediate ACT ba=0 -> err=0.
